// File: rtl/serial_word_comparator.sv
// Serial word magnitude comparator: folds per-digit (F1/F2/F3) flags, MSD first,
// into a registered gt/eq/lt word result offered over a valid/ready handshake.
module serial_word_comparator #(
  parameter int unsigned DIGITS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic in_first,
  input  logic F1,
  input  logic F2,
  input  logic F3,
  output logic in_ready,
  output logic out_valid,
  input  logic out_ready,
  output logic out_gt,
  output logic out_eq,
  output logic out_lt,
  output logic err
);

  localparam int unsigned CW = $clog2(DIGITS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    UNDECIDED = 2'd0,
    DEC_GT    = 2'd1,
    DEC_LT    = 2'd2
  } decision_t;

  state_t          state, state_n;
  decision_t       dec, dec_n;
  decision_t       dec_base;
  decision_t       digit_dec;
  logic [CW-1:0]   cnt, cnt_n;
  logic            out_valid_n, out_gt_n, out_eq_n, out_lt_n, err_n;
  logic            accept;
  logic            flags_ok;

  // Beats are taken whenever a result is not being held.
  assign in_ready = (state != HOLD);
  assign accept   = in_valid && in_ready;

  // Decode one digit's flags; anything not exactly one-hot counts as equal.
  always_comb begin
    flags_ok  = ({F1, F2, F3} == 3'b100) || ({F1, F2, F3} == 3'b010) ||
                ({F1, F2, F3} == 3'b001);
    digit_dec = UNDECIDED;
    if ({F1, F2, F3} == 3'b100) digit_dec = DEC_GT;
    if ({F1, F2, F3} == 3'b001) digit_dec = DEC_LT;
  end

  // Next-state, counter, decision and registered-output logic.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    dec_n       = dec;
    dec_base    = dec;
    out_valid_n = out_valid;
    out_gt_n    = out_gt;
    out_eq_n    = out_eq;
    out_lt_n    = out_lt;
    err_n       = 1'b0;

    case (state)
      IDLE, ACCUM: begin
        if (accept) begin
          if (!in_first && (state == IDLE)) begin
            // Continuation digit with no word open: drop it.
            err_n = 1'b1;
          end else begin
            // A first-digit marker inside a word aborts it and restarts.
            if (in_first && (state == ACCUM)) err_n = 1'b1;
            if (!flags_ok) err_n = 1'b1;
            dec_base = in_first ? UNDECIDED : dec;
            dec_n    = (dec_base == UNDECIDED) ? digit_dec : dec_base;
            cnt_n    = in_first ? CW'(1) : cnt + CW'(1);
            if (cnt_n == CW'(DIGITS)) begin
              state_n     = HOLD;
              out_valid_n = 1'b1;
              out_gt_n    = (dec_n == DEC_GT);
              out_lt_n    = (dec_n == DEC_LT);
              out_eq_n    = (dec_n == UNDECIDED);
            end else begin
              state_n = ACCUM;
            end
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_n     = IDLE;
          cnt_n       = '0;
          dec_n       = UNDECIDED;
          out_valid_n = 1'b0;
          out_gt_n    = 1'b0;
          out_eq_n    = 1'b0;
          out_lt_n    = 1'b0;
        end
      end
      default: begin
        state_n     = IDLE;
        cnt_n       = '0;
        dec_n       = UNDECIDED;
        out_valid_n = 1'b0;
        out_gt_n    = 1'b0;
        out_eq_n    = 1'b0;
        out_lt_n    = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      dec       <= UNDECIDED;
      out_valid <= 1'b0;
      out_gt    <= 1'b0;
      out_eq    <= 1'b0;
      out_lt    <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      dec       <= dec_n;
      out_valid <= out_valid_n;
      out_gt    <= out_gt_n;
      out_eq    <= out_eq_n;
      out_lt    <= out_lt_n;
      err       <= err_n;
    end
  end

endmodule

// File: tb/tb_serial_word_comparator.sv
// Bench for serial_word_comparator: 8-bit (DIGITS=4) and single-digit instances,
// checked against word-level integer comparison of the operands.
module tb_serial_word_comparator;

  localparam int unsigned D = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DIGITS=4 instance signals
  logic rst, in_valid, in_first, f1, f2, f3, out_ready;
  logic in_ready, out_valid, out_gt, out_eq, out_lt, err;
  // DIGITS=1 instance signals
  logic s_rst, s_in_valid, s_in_first, s_f1, s_f2, s_f3, s_out_ready;
  logic s_in_ready, s_out_valid, s_out_gt, s_out_eq, s_out_lt, s_err;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  serial_word_comparator #(.DIGITS(D)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first),
    .F1(f1), .F2(f2), .F3(f3), .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .out_gt(out_gt), .out_eq(out_eq), .out_lt(out_lt),
    .err(err)
  );

  serial_word_comparator #(.DIGITS(1)) u1 (
    .clk(clk), .rst(s_rst), .in_valid(s_in_valid), .in_first(s_in_first),
    .F1(s_f1), .F2(s_f2), .F3(s_f3), .in_ready(s_in_ready), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .out_gt(s_out_gt), .out_eq(s_out_eq), .out_lt(s_out_lt),
    .err(s_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Word-level magnitude result as {gt, eq, lt}
  function automatic logic [2:0] ref_res(input logic [7:0] a, input logic [7:0] b);
    if (a > b) return 3'b100;
    if (a < b) return 3'b001;
    return 3'b010;
  endfunction

  // Flags the upstream 2-bit comparator would produce for digit i
  function automatic logic [2:0] dflags(input logic [7:0] a, input logic [7:0] b, input int i);
    logic [1:0] da, db;
    da = a[2*i +: 2];
    db = b[2*i +: 2];
    return ref_res({6'b0, da}, {6'b0, db});
  endfunction

  function automatic logic [2:0] bad_flags();
    logic [2:0] set [5];
    set = '{3'b000, 3'b110, 3'b111, 3'b101, 3'b011};
    return set[$urandom_range(4, 0)];
  endfunction

  task automatic beat(input bit first, input logic [2:0] fl);
    in_valid = 1'b1;
    in_first = first;
    {f1, f2, f3} = fl;
    @(negedge clk);
    in_valid = 1'b0;
    in_first = 1'b0;
  endtask

  // Send a full word MSD first; digit 'bad' (or -1) carries non-one-hot flags.
  task automatic send_word(input logic [7:0] a, input logic [7:0] b, input int bad,
                           input int max_stall, input bit restart, output logic [2:0] exp);
    logic [7:0] bm;
    logic [2:0] fl;
    int k;
    bm = b;
    if (bad >= 0) bm[2*bad +: 2] = a[2*bad +: 2];
    exp = ref_res(a, bm);
    for (int i = int'(D) - 1; i >= 0; i--) begin
      if (max_stall > 0) begin
        k = int'($urandom_range(max_stall, 0));
        repeat (k) begin
          @(negedge clk);
          check("stall_valid", out_valid, 0);
          check("stall_ready", in_ready, 1);
        end
      end
      check("beat_ready", in_ready, 1);
      fl = (i == bad) ? bad_flags() : dflags(a, b, i);
      beat(i == int'(D) - 1, fl);
      check("beat_err", err, (i == bad) || (restart && i == int'(D) - 1));
      if (i > 0) check("mid_valid", out_valid, 0);
    end
    check("word_valid", out_valid, 1);
    check("word_ready", in_ready, 0);
    check("word_result", {out_gt, out_eq, out_lt}, exp);
  endtask

  // Hold the result n cycles (optionally offering beats), then release it.
  task automatic hold_release(input int n, input logic [2:0] exp, input bit offer);
    out_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_valid = offer;
      in_first = 1'b1;
      {f1, f2, f3} = 3'b100;
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_ready", in_ready, 0);
      check("hold_result", {out_gt, out_eq, out_lt}, exp);
      check("hold_err", err, 0);
    end
    in_valid  = 1'b0;
    in_first  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("rel_valid", out_valid, 0);
    check("rel_ready", in_ready, 1);
    check("rel_result", {out_gt, out_eq, out_lt}, 0);
    check("rel_err", err, 0);
  endtask

  task automatic reset_check(input string tag);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_ready"}, in_ready, 1);
    check({tag, "_err"}, err, 0);
    check({tag, "_result"}, {out_gt, out_eq, out_lt}, 0);
  endtask

  initial begin
    logic [2:0] exp;
    logic [7:0] a, b;
    logic [1:0] da, db;
    logic [2:0] fl;
    int bad;
    bit isbad;

    rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; {f1, f2, f3} = 3'b010; out_ready = 1'b0;
    s_rst = 1'b1; s_in_valid = 1'b0; s_in_first = 1'b0; {s_f1, s_f2, s_f3} = 3'b010;
    s_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset_check("reset");

    // Equal word
    send_word(8'hB4, 8'hB4, -1, 0, 1'b0, exp);
    check("eq_word", {out_gt, out_eq, out_lt}, 3'b010);
    hold_release(0, exp, 1'b0);

    // Most significant differing digit decides
    send_word(8'b01_11_11_11, 8'b10_00_00_00, -1, 0, 1'b0, exp);
    check("msd_lt", {out_gt, out_eq, out_lt}, 3'b001);
    hold_release(0, exp, 1'b0);

    // Stalls and backpressure with beats offered during HOLD
    send_word(8'h93, 8'h92, -1, 3, 1'b0, exp);
    check("bp_gt", {out_gt, out_eq, out_lt}, 3'b100);
    hold_release(5, exp, 1'b1);
    @(negedge clk);
    check("bp_no_accept", out_valid, 0);

    // Continuation beat in IDLE
    beat(1'b0, 3'b100);
    check("idle_cont_err", err, 1);
    check("idle_cont_valid", out_valid, 0);
    @(negedge clk);
    check("err_one_cycle", err, 0);
    send_word(8'h10, 8'h20, -1, 0, 1'b0, exp);
    hold_release(1, exp, 1'b0);

    // in_first on beat 3 restarts the word
    beat(1'b1, 3'b100);
    beat(1'b0, 3'b100);
    send_word(8'h3C, 8'h3D, -1, 0, 1'b1, exp);
    check("restart_lt", {out_gt, out_eq, out_lt}, 3'b001);
    hold_release(0, exp, 1'b0);

    // Flags 110 on the MSD count as equal
    in_valid = 1'b1; in_first = 1'b1; {f1, f2, f3} = 3'b110;
    @(negedge clk);
    in_valid = 1'b0; in_first = 1'b0;
    check("bad110_err", err, 1);
    for (int i = 0; i < 3; i++) beat(1'b0, 3'b010);
    check("bad110_result", {out_gt, out_eq, out_lt}, 3'b010);
    hold_release(0, 3'b010, 1'b0);

    // Reset after beat 2 and during HOLD
    beat(1'b1, 3'b100);
    beat(1'b0, 3'b001);
    reset_check("rst_mid");
    send_word(8'h55, 8'h54, -1, 1, 1'b0, exp);
    reset_check("rst_hold");
    send_word(8'h01, 8'h02, -1, 0, 1'b0, exp);
    hold_release(0, exp, 1'b0);

    // Randomized words
    for (int t = 0; t < 60; t++) begin
      a = 8'($urandom);
      if ($urandom_range(1, 0) == 1) begin
        b = a;
        b[2*$urandom_range(3, 0) +: 2] = 2'($urandom);
      end else begin
        b = 8'($urandom);
      end
      bad = ($urandom_range(4, 0) == 0) ? int'($urandom_range(3, 0)) : -1;
      send_word(a, b, bad, 2, 1'b0, exp);
      hold_release(int'($urandom_range(3, 0)), exp, 1'($urandom));
    end

    // DIGITS=1 instance
    s_rst = 1'b0;
    @(negedge clk);
    check("s_reset_valid", s_out_valid, 0);
    check("s_reset_ready", s_in_ready, 1);
    s_in_valid = 1'b1; s_in_first = 1'b0; {s_f1, s_f2, s_f3} = 3'b100;
    @(negedge clk);
    s_in_valid = 1'b0;
    check("s_cont_err", s_err, 1);
    check("s_cont_valid", s_out_valid, 0);
    for (int t = 0; t < 16; t++) begin
      da = 2'($urandom);
      db = 2'($urandom);
      isbad = (t > 0) && ($urandom_range(3, 0) == 0);
      fl = (t == 0) ? 3'b100 : (isbad ? bad_flags() : ref_res({6'b0, da}, {6'b0, db}));
      exp = (t == 0) ? 3'b100 : (isbad ? 3'b010 : ref_res({6'b0, da}, {6'b0, db}));
      check("s_ready", s_in_ready, 1);
      s_in_valid = 1'b1; s_in_first = 1'b1; {s_f1, s_f2, s_f3} = fl;
      @(negedge clk);
      s_in_valid = 1'b0; s_in_first = 1'b0;
      check("s_valid", s_out_valid, 1);
      check("s_hold_ready", s_in_ready, 0);
      check("s_result", {s_out_gt, s_out_eq, s_out_lt}, exp);
      check("s_err", s_err, isbad);
      s_out_ready = 1'b1;
      @(negedge clk);
      s_out_ready = 1'b0;
      check("s_rel_valid", s_out_valid, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
